step_incrementer_unit: RTL and testbench

STEP_INCREMENTER_UNIT -- requirements
Module: step_incrementer_unit

---
 rtl/step_incrementer_unit.sv | 144 ++++++++++++++
 tb/tb_step_incrementer_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_incrementer_unit.sv
// Step incrementer: applies Count single +/-1 steps to a selected operand, one step per clock,
// with a sticky wrap/limit flag and optional saturation at the numeric limits.
module step_incrementer_unit #(
  parameter int WIDTH     = 4,
  parameter int CNT_WIDTH = 4,
  parameter int SATURATE  = 0
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic                 Sel,
  input  logic                 Dec,
  input  logic [CNT_WIDTH-1:0] Count,
  input  logic                 In_Valid,
  output logic                 In_Ready,
  input  logic                 Abort,
  output logic [WIDTH-1:0]     Out,
  output logic                 Carry_Out_Inc,
  output logic                 Busy,
  output logic                 Out_Valid,
  input  logic                 Out_Ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_r;
  logic [WIDTH-1:0]     acc_r;
  logic                 dec_r;
  logic [CNT_WIDTH-1:0] remaining_r;
  logic [WIDTH-1:0]     out_r;
  logic                 carry_r;
  logic                 busy_r;
  logic                 valid_r;

  logic [WIDTH-1:0]     operand_s;
  logic                 at_limit_s;
  logic [WIDTH-1:0]     next_acc_s;

  // Operand selection for a new request
  always_comb begin
    operand_s = A;
    if (Sel) begin
      operand_s = B;
    end else begin
      operand_s = A;
    end
  end

  // One step of the accumulator; at_limit marks a step that starts at the wrap boundary
  always_comb begin
    at_limit_s = 1'b0;
    next_acc_s = acc_r;
    if (dec_r) begin
      at_limit_s = (acc_r == {WIDTH{1'b0}});
    end else begin
      at_limit_s = (acc_r == {WIDTH{1'b1}});
    end
    if (at_limit_s && (SATURATE != 0)) begin
      next_acc_s = acc_r;
    end else if (dec_r) begin
      next_acc_s = acc_r - {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      next_acc_s = acc_r + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // Control FSM with registered result, flag and handshake outputs
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_r     <= IDLE;
      acc_r       <= {WIDTH{1'b0}};
      dec_r       <= 1'b0;
      remaining_r <= {CNT_WIDTH{1'b0}};
      out_r       <= {WIDTH{1'b0}};
      carry_r     <= 1'b0;
      busy_r      <= 1'b0;
      valid_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (In_Valid) begin
            acc_r       <= operand_s;
            dec_r       <= Dec;
            remaining_r <= Count;
            carry_r     <= 1'b0;
            if (Count == {CNT_WIDTH{1'b0}}) begin
              out_r   <= operand_s;
              valid_r <= 1'b1;
              state_r <= DONE;
            end else begin
              busy_r  <= 1'b1;
              state_r <= RUN;
            end
          end
        end
        RUN: begin
          if (Abort) begin
            busy_r      <= 1'b0;
            valid_r     <= 1'b0;
            remaining_r <= {CNT_WIDTH{1'b0}};
            state_r     <= IDLE;
          end else begin
            acc_r       <= next_acc_s;
            remaining_r <= remaining_r - {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            if (at_limit_s) begin
              carry_r <= 1'b1;
            end
            // Last step publishes the result on the same edge it is computed
            if (remaining_r == {{(CNT_WIDTH-1){1'b0}}, 1'b1}) begin
              out_r   <= next_acc_s;
              valid_r <= 1'b1;
              busy_r  <= 1'b0;
              state_r <= DONE;
            end
          end
        end
        DONE: begin
          if (Out_Ready) begin
            valid_r <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          busy_r      <= 1'b0;
          valid_r     <= 1'b0;
          remaining_r <= {CNT_WIDTH{1'b0}};
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign In_Ready      = (state_r == IDLE);
  assign Out           = out_r;
  assign Carry_Out_Inc = carry_r;
  assign Busy          = busy_r;
  assign Out_Valid     = valid_r;

endmodule

// File: tb/tb_step_incrementer_unit.sv
// Bench for step_incrementer_unit: wrapping and saturating instances share stimulus and are
// checked every cycle against a transaction-level arithmetic model, plus directed literal cases.
module tb_step_incrementer_unit;

  logic       Clk;
  logic       Rst_n;
  logic [3:0] a, b, count;
  logic       sel, dec, in_valid, abort, out_ready;

  logic [3:0] w_out, s_out;
  logic       w_carry, s_carry, w_busy, s_busy, w_valid, s_valid, w_in_ready, s_in_ready;

  int n_pass  = 0;
  int n_total = 0;

  step_incrementer_unit #(.WIDTH(4), .CNT_WIDTH(4), .SATURATE(0)) u_wrap (
    .Clk(Clk), .Rst_n(Rst_n), .A(a), .B(b), .Sel(sel), .Dec(dec), .Count(count),
    .In_Valid(in_valid), .In_Ready(w_in_ready), .Abort(abort), .Out(w_out),
    .Carry_Out_Inc(w_carry), .Busy(w_busy), .Out_Valid(w_valid), .Out_Ready(out_ready)
  );

  step_incrementer_unit #(.WIDTH(4), .CNT_WIDTH(4), .SATURATE(1)) u_sat (
    .Clk(Clk), .Rst_n(Rst_n), .A(a), .B(b), .Sel(sel), .Dec(dec), .Count(count),
    .In_Valid(in_valid), .In_Ready(s_in_ready), .Abort(abort), .Out(s_out),
    .Carry_Out_Inc(s_carry), .Busy(s_busy), .Out_Valid(s_valid), .Out_Ready(out_ready)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Result after j steps from op, by plain arithmetic
  function automatic int m_value(input int op, input bit d, input int j, input bit sat);
    int v;
    v = d ? (op - j) : (op + j);
    if (sat) begin
      if (v > 15) v = 15;
      if (v < 0) v = 0;
    end else begin
      v = v & 15;
    end
    return v;
  endfunction

  // Some step among the first j started at the boundary
  function automatic bit m_flag(input int op, input bit d, input int j);
    return d ? (j > op) : (op + j > 15);
  endfunction

  int m_state;  // 0 idle, 1 stepping, 2 holding result
  int m_op, m_n, m_j;
  bit m_dec, m_flag_r, m_valid, m_busy;
  int m_out [2];

  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      m_state <= 0; m_op <= 0; m_n <= 0; m_j <= 0; m_dec <= 0;
      m_flag_r <= 0; m_valid <= 0; m_busy <= 0; m_out[0] <= 0; m_out[1] <= 0;
    end else begin
      if (m_state == 0) begin
        if (in_valid) begin
          m_op <= sel ? int'(b) : int'(a);
          m_dec <= dec; m_n <= int'(count); m_j <= 0; m_flag_r <= 0;
          if (count == 4'd0) begin
            m_out[0] <= sel ? int'(b) : int'(a);
            m_out[1] <= sel ? int'(b) : int'(a);
            m_valid <= 1; m_state <= 2;
          end else begin
            m_busy <= 1; m_state <= 1;
          end
        end
      end else if (m_state == 1) begin
        if (abort) begin
          m_busy <= 0; m_state <= 0;
        end else begin
          m_j <= m_j + 1;
          m_flag_r <= m_flag(m_op, m_dec, m_j + 1);
          if (m_j + 1 == m_n) begin
            m_out[0] <= m_value(m_op, m_dec, m_n, 1'b0);
            m_out[1] <= m_value(m_op, m_dec, m_n, 1'b1);
            m_valid <= 1; m_busy <= 0; m_state <= 2;
          end
        end
      end else begin
        if (out_ready) begin
          m_valid <= 0; m_state <= 0;
        end
      end
    end
  end

  // Cycle-by-cycle comparison of both instances against the model
  always @(negedge Clk) begin
    check("wrap_out", w_out, m_out[0]);
    check("sat_out", s_out, m_out[1]);
    check("wrap_carry", w_carry, m_flag_r);
    check("sat_carry", s_carry, m_flag_r);
    check("wrap_busy", w_busy, m_busy);
    check("sat_busy", s_busy, m_busy);
    check("wrap_out_valid", w_valid, m_valid);
    check("sat_out_valid", s_valid, m_valid);
    check("wrap_in_ready", w_in_ready, (m_state == 0) ? 1 : 0);
    check("sat_in_ready", s_in_ready, (m_state == 0) ? 1 : 0);
    check("ready_valid_exclusive", w_in_ready & w_valid, 0);
  end

  task automatic step();
    @(posedge Clk); #1;
  endtask

  // Issue one request from IDLE and count edges after the accepting edge until Out_Valid
  task automatic do_op(input logic s, input logic [3:0] av, input logic [3:0] bv,
                       input logic d, input logic [3:0] c, output int lat);
    sel = s; a = av; b = bv; dec = d; count = c; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!w_valid && lat < 40) begin
      step();
      lat++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  int lat;

  initial begin
    Rst_n = 1'b0; a = 4'd0; b = 4'd0; count = 4'd0; sel = 1'b0; dec = 1'b0;
    in_valid = 1'b0; abort = 1'b0; out_ready = 1'b0;
    step(); step();
    check("reset_out", w_out, 0);
    check("reset_valid", w_valid, 0);
    check("reset_busy", w_busy, 0);
    check("reset_in_ready", w_in_ready, 1);
    Rst_n = 1'b1;
    step();

    // 0111 + 1 step
    sel = 1'b0; a = 4'b0111; dec = 1'b0; count = 4'd1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("req035_busy_after_accept", w_busy, 1);
    check("req035_valid_after_accept", w_valid, 0);
    step();
    check("req035_valid", w_valid, 1);
    check("req035_out", w_out, 4'b1000);
    check("req035_carry", w_carry, 0);
    release_result();
    check("req035_back_idle", w_in_ready, 1);

    // B=1110 + 3 steps wraps through all-ones
    do_op(1'b1, 4'd0, 4'b1110, 1'b0, 4'd3, lat);
    check("req036_latency", lat, 3);
    check("req036_out", w_out, 4'b0001);
    check("req036_carry", w_carry, 1);
    check("req036_sat_out", s_out, 4'b1111);
    release_result();

    // Saturating limits in both directions
    do_op(1'b0, 4'b0001, 4'd0, 1'b1, 4'd4, lat);
    check("req037_sat_dec_out", s_out, 4'b0000);
    check("req037_sat_dec_carry", s_carry, 1);
    check("req037_wrap_dec_out", w_out, 4'b1101);
    release_result();
    do_op(1'b0, 4'b1110, 4'd0, 1'b0, 4'd5, lat);
    check("req037_sat_inc_out", s_out, 4'b1111);
    check("req037_sat_inc_carry", s_carry, 1);
    check("req037_wrap_inc_out", w_out, 4'b0011);
    release_result();

    // Count=0 is a pass-through with zero latency
    do_op(1'b0, 4'b1010, 4'd0, 1'b0, 4'd0, lat);
    check("req038_latency", lat, 0);
    check("req038_out", w_out, 4'b1010);
    check("req038_carry", w_carry, 0);
    release_result();

    // Maximum count
    do_op(1'b0, 4'd0, 4'd0, 1'b0, 4'd15, lat);
    check("maxcount_latency", lat, 15);
    check("maxcount_out", w_out, 15);
    check("maxcount_carry", w_carry, 0);
    release_result();

    // Result held under back-pressure while new requests are offered
    do_op(1'b0, 4'd3, 4'd0, 1'b0, 4'd2, lat);
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid; a = 4'($urandom); b = 4'($urandom); count = 4'($urandom);
      sel = 1'($urandom); dec = 1'($urandom);
      step();
      check("req039_out_stable", w_out, 5);
      check("req039_in_ready", w_in_ready, 0);
      check("req039_valid_held", w_valid, 1);
    end
    in_valid = 1'b0;
    release_result();
    check("req039_idle_after_ready", w_in_ready, 1);

    // Abort on the third stepping edge
    sel = 1'b0; a = 4'd5; dec = 1'b0; count = 4'd8; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      check("req040_no_valid", w_valid, 0);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("req040_abort_idle", w_in_ready, 1);
    check("req040_abort_busy", w_busy, 0);
    check("req040_abort_valid", w_valid, 0);
    check("req040_abort_out_kept", w_out, 5);
    step();
    check("req040_abort_stays_idle", w_valid, 0);

    // Asynchronous reset mid-run, then a normal accept
    sel = 1'b0; a = 4'd9; dec = 1'b0; count = 4'd10; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    Rst_n = 1'b0;
    #1;
    check("async_rst_out", w_out, 0);
    check("async_rst_busy", w_busy, 0);
    check("async_rst_valid", w_valid, 0);
    check("async_rst_carry", w_carry, 0);
    step();
    Rst_n = 1'b1;
    do_op(1'b0, 4'd2, 4'd0, 1'b0, 4'd1, lat);
    check("post_reset_latency", lat, 1);
    check("post_reset_out", w_out, 3);
    release_result();

    // Randomized traffic checked by the model every cycle
    for (int i = 0; i < 2000; i++) begin
      in_valid = 1'($urandom); a = 4'($urandom); b = 4'($urandom);
      sel = 1'($urandom); dec = 1'($urandom); count = 4'($urandom);
      abort = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    in_valid = 1'b0; abort = 1'b0; out_ready = 1'b0;
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
